// File: rtl/dac_spi_tx_if.sv
// rtl/dac_spi_tx_if.sv - sample handshake and SPI pin bundle for dac_spi_tx
//
// Purpose: groups the sample handshake (data_in/valid_in/ready_out/busy_out)
// and the SPI pins (sclk/mosi/cs) of one DAC channel.
// Modports:
//   master - upstream sample source: drives data_in/valid_in, observes the rest
//   slave  - dac_spi_tx: receives data_in/valid_in, drives status and SPI pins
interface dac_spi_tx_if;
  logic [11:0] data_in;
  logic        valid_in;
  logic        ready_out;
  logic        busy_out;
  logic        sclk;
  logic        mosi;
  logic        cs;

  modport master (
    output data_in, valid_in,
    input  ready_out, busy_out, sclk, mosi, cs
  );

  modport slave (
    input  data_in, valid_in,
    output ready_out, busy_out, sclk, mosi, cs
  );
endinterface

// File: rtl/dac_spi_tx.sv
// rtl/dac_spi_tx.sv - SPI mode-0 serializer for one 12-bit MCP4921-class DAC
//
// Purpose: accepts one 12-bit sample per valid/ready handshake, prepends the
// 4 config bits and shifts the 16-bit word out MSB-first with cs framing,
// followed by a fixed cs-high gap before the next sample is accepted.
// Ports:
//   clock_in  - system clock, rising edge
//   reset_in  - synchronous, active-high reset
//   bus       - dac_spi_tx_if.slave: data_in/valid_in in; ready_out,
//               busy_out, sclk, mosi, cs out
module dac_spi_tx #(
  parameter int         CLK_DIV    = 4,
  parameter logic [3:0] CFG_BITS   = 4'b0111,
  parameter int         GAP_CYCLES = 4
) (
  input logic         clock_in,
  input logic         reset_in,
  dac_spi_tx_if.slave bus
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [3:0]    bit_q, bit_d;
  logic [15:0]   shreg_q, shreg_d;
  logic          sclk_q, sclk_d;
  logic          cs_q, cs_d;
  logic          mosi_q, mosi_d;

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      div_q   <= '0;
      gap_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      gap_q   <= gap_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
    end
  end

  // SPI pins are registered so they never glitch; each is set one cycle
  // ahead from the next-state decision below.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    gap_d   = gap_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;

    case (state_q)
      IDLE: begin
        if (bus.valid_in) begin
          shreg_d = {CFG_BITS, bus.data_in};
          mosi_d  = CFG_BITS[3];
          cs_d    = 1'b0;
          div_d   = '0;
          state_d = SETUP;
        end
      end

      SETUP: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b1;
          state_d = SHIFT;
        end else begin
          div_d = div_q + DW'(1);
        end
      end

      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (sclk_q) begin
            // Falling edge: present the next bit, except after the last one,
            // which must stay on mosi through the hold phase.
            sclk_d = 1'b0;
            if (bit_q != 4'd15) begin
              shreg_d = {shreg_q[14:0], 1'b0};
              mosi_d  = shreg_q[14];
            end
          end else if (bit_q == 4'd15) begin
            state_d = HOLD;
          end else begin
            bit_d  = bit_q + 4'd1;
            sclk_d = 1'b1;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end

      HOLD: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          gap_d   = '0;
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          state_d = GAP;
        end else begin
          div_d = div_q + DW'(1);
        end
      end

      GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        sclk_d  = 1'b0;
        cs_d    = 1'b1;
        mosi_d  = 1'b0;
      end
    endcase
  end

  assign bus.ready_out = (state_q == IDLE);
  assign bus.busy_out  = (state_q != IDLE);
  assign bus.sclk      = sclk_q;
  assign bus.mosi      = mosi_q;
  assign bus.cs        = cs_q;

endmodule
